// File: rtl/wide_add_sequencer_if.sv
// Bundles the request, external-adder and result handshakes of wide_add_sequencer.
// The slave view belongs to the sequencer; the master view belongs to its surroundings.
interface wide_add_sequencer_if #(
    parameter int WORDS = 2
);
    localparam int W = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;

    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_sum;
    logic         add_cout;
    logic         add_ovf;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin,
        output in_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout, add_ovf,
        output out_valid, out_result, out_cout, out_ovf, out_zero,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin,
        input  in_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout, add_ovf,
        input  out_valid, out_result, out_cout, out_ovf, out_zero,
        output out_ready
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built by walking one 32-bit word per cycle through an external
// ripple-carry adder, chaining the carry, and presenting the result on a valid/ready port.
module wide_add_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);
    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    opA_q;
    logic [W-1:0]    opB_q;
    logic            sub_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic            nonZero_q;

    logic            outValid_q;
    logic [W-1:0]    outResult_q;
    logic            outCout_q;
    logic            outOvf_q;
    logic            outZero_q;

    logic [31:0]     addA;
    logic [31:0]     addB;
    logic            addCin;

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry loaded at accept.
    always_comb begin
        addA   = '0;
        addB   = '0;
        addCin = 1'b0;
        acc_d  = acc_q;
        acc_d[32*idx_q +: 32] = bus.add_sum;
        if (state_q == RUN) begin
            addA   = opA_q[32*idx_q +: 32];
            addB   = sub_q ? ~opB_q[32*idx_q +: 32] : opB_q[32*idx_q +: 32];
            addCin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            opA_q       <= '0;
            opB_q       <= '0;
            sub_q       <= 1'b0;
            acc_q       <= '0;
            nonZero_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outCout_q   <= 1'b0;
            outOvf_q    <= 1'b0;
            outZero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opA_q     <= bus.in_a;
                        opB_q     <= bus.in_b;
                        sub_q     <= bus.in_sub;
                        carry_q   <= bus.in_sub ? 1'b1 : bus.in_cin;
                        idx_q     <= '0;
                        nonZero_q <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    carry_q   <= bus.add_cout;
                    nonZero_q <= nonZero_q | (bus.add_sum != 32'd0);
                    // Overflow is meaningful only on the top word, which is the last one processed.
                    if (idx_q == LAST_IDX) begin
                        outResult_q <= acc_d;
                        outCout_q   <= bus.add_cout;
                        outOvf_q    <= bus.add_ovf;
                        outZero_q   <= !nonZero_q && (bus.add_sum == 32'd0);
                        outValid_q  <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.add_a      = addA;
    assign bus.add_b      = addB;
    assign bus.add_cin    = addCin;
    assign bus.out_valid  = outValid_q;
    assign bus.out_result = outResult_q;
    assign bus.out_cout   = outCout_q;
    assign bus.out_ovf    = outOvf_q;
    assign bus.out_zero   = outZero_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: a 2-word and a 4-word instance, each fed by
// a behavioural 32-bit adder, checked against a plain-arithmetic reference of the full operation.
module tb_wide_add_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wide_add_sequencer_if #(.WORDS(2)) bus2();
    wide_add_sequencer_if #(.WORDS(4)) bus4();

    wide_add_sequencer #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    wide_add_sequencer #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // The external 32-bit ripple-carry adder each sequencer drives.
    assign {bus2.add_cout, bus2.add_sum} = {1'b0, bus2.add_a} + {1'b0, bus2.add_b} + {32'd0, bus2.add_cin};
    assign bus2.add_ovf = (bus2.add_a[31] == bus2.add_b[31]) && (bus2.add_sum[31] != bus2.add_a[31]);
    assign {bus4.add_cout, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {32'd0, bus4.add_cin};
    assign bus4.add_ovf = (bus4.add_a[31] == bus4.add_b[31]) && (bus4.add_sum[31] != bus4.add_a[31]);

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {cout, ovf, result[127:0]} for a w-bit add (a+b+cin) or subtract (a-b).
    function automatic logic [129:0] refModel(input int w, input logic [127:0] a, input logic [127:0] b,
                                              input logic sub, input logic cin);
        logic [127:0]        mask;
        logic [128:0]        ua, ub, total;
        logic signed [130:0] sa, sb, sres, lim;
        logic                cout, ovf;
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        ua = {1'b0, a & mask};
        ub = {1'b0, b & mask};
        if (sub) begin
            cout  = (ua >= ub);
            total = ua - ub;
        end else begin
            total = ua + ub + 129'(cin);
            cout  = total[w];
        end
        lim = 131'sd1 <<< (w - 1);
        sa = $signed({2'b00, ua});
        sb = $signed({2'b00, ub});
        if (a[w-1]) sa = sa - (lim <<< 1);
        if (b[w-1]) sb = sb - (lim <<< 1);
        sres = sub ? (sa - sb) : (sa + sb + $signed({130'd0, cin}));
        ovf  = (sres >= lim) || (sres < -lim);
        return {cout, ovf, total[127:0] & mask};
    endfunction

    // Carry entering word i: carry out of the sum of the lower i words.
    function automatic logic expCin(input int i, input logic [127:0] a, input logic [127:0] b,
                                    input logic sub, input logic cin);
        logic [128:0] m, x, y, s;
        logic         c0;
        c0 = sub ? 1'b1 : cin;
        if (i == 0) return c0;
        m = (129'd1 << (32 * i)) - 129'd1;
        x = {1'b0, a} & m;
        y = {1'b0, sub ? ~b : b} & m;
        s = x + y + 129'(c0);
        return s[32*i];
    endfunction

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                 input logic cin, input int hold);
        logic [129:0] exp;
        logic [63:0]  bx;
        int           cyc;
        exp = refModel(64, {64'd0, a}, {64'd0, b}, sub, cin);
        bx  = sub ? ~b : b;
        @(negedge clk);
        checkOutput("idle_ready", bus2.in_ready, 1);
        bus2.in_a = a; bus2.in_b = b; bus2.in_sub = sub; bus2.in_cin = cin; bus2.in_valid = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus2.in_valid = 1'b0;
            bus2.in_a = {$urandom, $urandom};
            bus2.in_b = {$urandom, $urandom};
            bus2.in_sub = 1'($urandom);
            bus2.in_cin = 1'($urandom);
            bus2.out_ready = (cyc == 1);
            if (cyc <= 2) begin
                checkOutput("run_ready", bus2.in_ready, 0);
                checkOutput("add_a", bus2.add_a, a[32*(cyc-1) +: 32]);
                checkOutput("add_b", bus2.add_b, bx[32*(cyc-1) +: 32]);
                checkOutput("add_cin", bus2.add_cin, expCin(cyc - 1, {64'd0, a}, {64'd0, b}, sub, cin));
            end
        end while (!bus2.out_valid && cyc < 20);
        bus2.out_ready = 1'b0;
        checkOutput("latency", cyc - 1, 2);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("out_valid", bus2.out_valid, 1);
            checkOutput("result", bus2.out_result, exp[63:0]);
            checkOutput("cout", bus2.out_cout, exp[129]);
            checkOutput("ovf", bus2.out_ovf, exp[128]);
            checkOutput("zero", bus2.out_zero, exp[63:0] == 64'd0);
            checkOutput("done_ready", bus2.in_ready, 0);
            checkOutput("idle_drive", {bus2.add_cin, bus2.add_a, bus2.add_b}, 0);
            bus2.in_valid = (k < hold) ? 1'($urandom) : 1'b0;
        end
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        checkOutput("released_valid", bus2.out_valid, 0);
        checkOutput("released_ready", bus2.in_ready, 1);
        checkOutput("kept_result", bus2.out_result, exp[63:0]);
    endtask

    task automatic runWide(input logic [127:0] a, input logic [127:0] b, input logic sub, input logic cin);
        logic [129:0] exp;
        int           cyc;
        exp = refModel(128, a, b, sub, cin);
        @(negedge clk);
        bus4.in_a = a; bus4.in_b = b; bus4.in_sub = sub; bus4.in_cin = cin; bus4.in_valid = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus4.in_valid = 1'b0;
        end while (!bus4.out_valid && cyc < 30);
        checkOutput("w4_latency", cyc - 1, 4);
        checkOutput("w4_result", bus4.out_result, exp[127:0]);
        checkOutput("w4_cout", bus4.out_cout, exp[129]);
        checkOutput("w4_ovf", bus4.out_ovf, exp[128]);
        checkOutput("w4_zero", bus4.out_zero, exp[127:0] == 128'd0);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        checkOutput("w4_released", bus4.out_valid, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL timeout: time %0t exceeded limit", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [63:0] ra, rb;
        rst = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_sub = 1'b0; bus2.in_cin = 1'b0;
        bus2.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_sub = 1'b0; bus4.in_cin = 1'b0;
        bus4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", bus2.out_valid, 0);
        checkOutput("rst_ready", bus2.in_ready, 1);
        checkOutput("rst_zero", bus2.out_zero, 1);
        checkOutput("rst_result", bus2.out_result, 0);
        checkOutput("rst_flags", {bus2.out_cout, bus2.out_ovf}, 0);
        checkOutput("rst_drive", {bus2.add_cin, bus2.add_a, bus2.add_b}, 0);
        rst = 1'b0;

        applyStimulus(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 0);
        applyStimulus(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 0);
        applyStimulus(64'h0, 64'h1, 1'b1, 1'b0, 0);
        applyStimulus(64'h5, 64'h5, 1'b1, 1'b0, 5);
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b1, 1);

        // Abort an operation during its first RUN cycle.
        @(negedge clk);
        bus2.in_a = 64'h1234; bus2.in_b = 64'h5678; bus2.in_sub = 1'b0; bus2.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checkOutput("abort_running", bus2.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", bus2.out_valid, 0);
        checkOutput("abort_zero", bus2.out_zero, 1);
        checkOutput("abort_ready", bus2.in_ready, 1);
        checkOutput("abort_result", bus2.out_result, 0);
        @(negedge clk);
        checkOutput("abort_no_valid", bus2.out_valid, 0);
        applyStimulus(64'd3, 64'd4, 1'b0, 1'b0, 0);

        for (int n = 0; n < 25; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ~ra;
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        runWide({32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 128'h1, 1'b0, 1'b0);
        runWide({32'h0, 32'h0, 32'h0, 32'h9}, {32'h0, 32'h0, 32'h0, 32'h9}, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            runWide({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
